led_breathe_chaser: RTL and testbench
=====================================

Name: led_breathe_chaser

Overview:
- Downstream consumer of the on-board clock source; drives the eight board LEDs (D1–D8) directly.
- Produces a PWM "breathing" brightness ramp on one active LED at a time.
- The active LED advances after each full breathe cycle, giving a chase pattern.
- Replaces the fixed toggle-counter LED driver in top-level designs that need visible activity with brightness control.

Parameters:
- TICK_DIV, 46875, clocks per brightness tick; must be ≥2.
- PWM_W, 8, width of the PWM counter and duty register; full scale MAX = 2^PWM_W-1.
- HOLD_TICKS, 32, ticks spent in each hold state; must be ≥1.
- CHANNELS, 8, number of LED outputs; must be ≥1.

Ports:
- clk  input  1  system clock from the block clock source.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  run enable, level-sensitive.
- led_out  output  CHANNELS  LED drive, 1 = lit; bit 0 maps to D1.
- active_ch  output  clog2(CHANNELS) (min 1)  index of the currently breathing LED.
- state_out  output  3  FSM state encoding.
- cycle_done  output  1  one-clock pulse at the end of each breathe cycle.

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: every register and output is 0, state is IDLE, active_ch is 0.
- FSM encoding: IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4. Values 5–7 are unreachable; if entered, the FSM returns to IDLE on the next clock.
- Prescaler:
  - Cleared to 0 in IDLE.
  - Otherwise counts 0..TICK_DIV-1 and wraps to 0.
  - tick is combinational, high while prescaler == TICK_DIV-1. All tick actions below take effect on that edge.
- PWM counter:
  - PWM_W bits, free-running while state != IDLE, wraps MAX→0.
  - Cleared in IDLE.
- Transitions:
  - IDLE: duty=0. en=1 → RAMP_UP on the next edge.
  - RAMP_UP, on tick: if duty==MAX → HOLD_HI with hold_cnt=0; else duty+1.
  - HOLD_HI, on tick: if hold_cnt==HOLD_TICKS-1 → RAMP_DN; else hold_cnt+1.
  - RAMP_DN, on tick: if duty==0 → HOLD_LO with hold_cnt=0; else duty-1.
  - HOLD_LO, on tick: if hold_cnt==HOLD_TICKS-1 → RAMP_UP, cycle_done=1 for one clock, and active_ch advances (CHANNELS-1 wraps to 0); else hold_cnt+1.
- Disable: en=0 in any state → IDLE on the next edge. Prescaler, PWM counter, duty and hold_cnt clear; led_out=0. active_ch is retained.
- Simultaneity: en=0 coinciding with the last HOLD_LO tick gives IDLE. No cycle_done pulse and no channel advance.
- Output:
  - led_out[active_ch] is registered (pwm_cnt < eff_duty); one clock of latency from the compare.
  - All other bits are 0.
  - eff_duty=0 → never lit. eff_duty=MAX → lit MAX of every 2^PWM_W clocks (never 100 %).
- Timing: duty never overflows or underflows. A full breathe cycle is (2·(MAX+1) + 2·HOLD_TICKS)·TICK_DIV clocks, measured from RAMP_UP entry to the cycle_done edge.
- Mid-operation reset: asynchronous clear to the reset values above. Operation resumes from IDLE once rst falls and en=1.

Optional Feature:
- Macro: LED_BREATHE_GAMMA_EN.
- Defined: eff_duty = (duty·duty) >> PWM_W, computed combinationally with no added latency. Perceptual gamma ≈2; duty=MAX gives eff_duty=MAX-1 (254 for PWM_W=8).
- Undefined: eff_duty = duty (linear).
- FSM, timing and cycle_done are identical in both builds.

Test Plan:
Bench parameters: TICK_DIV=4, PWM_W=4, HOLD_TICKS=2, CHANNELS=4, macro undefined unless stated.
1. Reset: assert rst asynchronously mid-clock → led_out=0, state_out=0, active_ch=0, cycle_done=0 immediately. Hold en=0 for 50 clocks → no change.
2. Full cycle: raise en at edge E0 → state_out=1 after E0; duty reaches 15 at E60; HOLD_HI at E64; RAMP_DN at E72; HOLD_LO at E136; cycle_done high exactly one clock after E144; active_ch=1.
3. PWM duty: with duty frozen at 5 in RAMP_UP → led_out[0] high exactly 5 of every 16 clocks (allowing one clock of latency); led_out[3:1]=0.
4. Chase wrap: run 4 full cycles → active_ch sequence 1,2,3,0. Exactly 4 cycle_done pulses, 144 clocks apart.
5. Disable: drop en during RAMP_DN → state_out=0 on the next clock, led_out=0, active_ch retained. Re-raise en → ramp restarts from duty 0.
6. Gamma build with LED_BREATHE_GAMMA_EN defined: duty=15 → eff_duty=14, lit 14/16 clocks; duty=4 → eff_duty=1, lit 1/16 clocks.

Source files
------------

// File: rtl/led_breathe_chaser.sv
// PWM breathing LED chaser: one LED ramps up, holds, ramps down, holds, then the next LED takes over.
// Optional build macro LED_BREATHE_GAMMA_EN applies a squared (gamma ~2) brightness curve.
module led_breathe_chaser #(
    parameter int TICK_DIV   = 46875,
    parameter int PWM_W      = 8,
    parameter int HOLD_TICKS = 32,
    parameter int CHANNELS   = 8,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [CHANNELS-1:0] led_out,
    output logic [CH_W-1:0]     active_ch,
    output logic [2:0]          state_out,
    output logic                cycle_done
);

    localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PWM_W-1:0]  DUTY_MAX  = '1;
    localparam logic [DIV_W-1:0]  PRESC_TOP = DIV_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [CH_W-1:0]   CH_TOP    = CH_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP_UP = 3'd1,
        HOLD_HI = 3'd2,
        RAMP_DN = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [DIV_W-1:0]    r_presc;
    logic [PWM_W-1:0]    r_pwm;
    logic [PWM_W-1:0]    r_duty;
    logic [PWM_W-1:0]    w_nextDuty;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_nextHold;
    logic [CH_W-1:0]     r_activeCh;
    logic [CHANNELS-1:0] r_led;
    logic [CHANNELS-1:0] w_ledNext;
    logic                r_cycleDone;
    logic                w_cycleDone;
    logic                w_advance;
    logic                w_tick;
    logic                w_run;
    logic                w_lit;
    logic [PWM_W-1:0]    w_effDuty;

    // Counters only run in a legal active state with en held high; anything else parks them at zero.
    assign w_run  = en && (r_state inside {RAMP_UP, HOLD_HI, RAMP_DN, HOLD_LO});
    assign w_tick = (r_presc == PRESC_TOP);

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*PWM_W-1:0] w_sq;
    assign w_sq      = {{PWM_W{1'b0}}, r_duty} * {{PWM_W{1'b0}}, r_duty};
    assign w_effDuty = w_sq[2*PWM_W-1:PWM_W];
`else
    assign w_effDuty = r_duty;
`endif

    assign w_lit = (r_pwm < w_effDuty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Dropping en overrides every transition, including the final HOLD_LO tick.
    always_comb begin
        w_nextState = r_state;
        w_nextDuty  = r_duty;
        w_nextHold  = r_hold;
        w_cycleDone = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextDuty = '0;
                w_nextHold = '0;
                if (en) begin
                    w_nextState = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (w_tick) begin
                    if (r_duty == DUTY_MAX) begin
                        w_nextState = HOLD_HI;
                        w_nextHold  = '0;
                    end else begin
                        w_nextDuty = r_duty + PWM_W'(1);
                    end
                end
            end
            HOLD_HI: begin
                if (w_tick) begin
                    if (r_hold == HOLD_TOP) begin
                        w_nextState = RAMP_DN;
                    end else begin
                        w_nextHold = r_hold + HOLD_W'(1);
                    end
                end
            end
            RAMP_DN: begin
                if (w_tick) begin
                    if (r_duty == '0) begin
                        w_nextState = HOLD_LO;
                        w_nextHold  = '0;
                    end else begin
                        w_nextDuty = r_duty - PWM_W'(1);
                    end
                end
            end
            HOLD_LO: begin
                if (w_tick) begin
                    if (r_hold == HOLD_TOP) begin
                        w_nextState = RAMP_UP;
                        w_cycleDone = 1'b1;
                        w_advance   = 1'b1;
                    end else begin
                        w_nextHold = r_hold + HOLD_W'(1);
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextDuty  = '0;
                w_nextHold  = '0;
            end
        endcase
        if (!en) begin
            w_nextState = IDLE;
            w_nextDuty  = '0;
            w_nextHold  = '0;
            w_cycleDone = 1'b0;
            w_advance   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_pwm   <= '0;
        end else if (!w_run) begin
            r_presc <= '0;
            r_pwm   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
            r_pwm   <= r_pwm + PWM_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty      <= '0;
            r_hold      <= '0;
            r_cycleDone <= 1'b0;
            r_activeCh  <= '0;
        end else begin
            r_duty      <= w_nextDuty;
            r_hold      <= w_nextHold;
            r_cycleDone <= w_cycleDone;
            if (w_advance) begin
                r_activeCh <= (r_activeCh == CH_TOP) ? '0 : r_activeCh + CH_W'(1);
            end
        end
    end

    always_comb begin
        w_ledNext = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_activeCh == CH_W'(i)) begin
                w_ledNext[i] = w_lit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_run ? w_ledNext : '0;
        end
    end

    assign led_out    = r_led;
    assign active_ch  = r_activeCh;
    assign state_out  = r_state;
    assign cycle_done = r_cycleDone;

endmodule

// File: tb/tb_led_breathe_chaser.sv
// Self-checking bench for led_breathe_chaser: randomized run lengths and disable points compared
// each clock against an arithmetic model of the breathe schedule (honours LED_BREATHE_GAMMA_EN).
module tb_led_breathe_chaser;

    localparam int TDIV    = 4;
    localparam int PW      = 4;
    localparam int HT      = 2;
    localparam int NCH     = 4;
    localparam int MAXV    = (1 << PW) - 1;
    localparam int UT      = MAXV + 1;
    localparam int PER_T   = 2 * UT + 2 * HT;
    localparam int PER_CLK = PER_T * TDIV;

    logic           clk;
    logic           rst;
    logic           en;
    logic [NCH-1:0] led_out;
    logic [1:0]     active_ch;
    logic [2:0]     state_out;
    logic           cycle_done;
    logic [9:0]     obs;
    logic [9:0]     expObs;

    int nCheck;
    int nBad;
    int kNow;
    int baseCh;

    led_breathe_chaser #(
        .TICK_DIV  (TDIV),
        .PWM_W     (PW),
        .HOLD_TICKS(HT),
        .CHANNELS  (NCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .led_out   (led_out),
        .active_ch (active_ch),
        .state_out (state_out),
        .cycle_done(cycle_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {state_out, active_ch, cycle_done, led_out};

    function automatic int effOf(input int d);
`ifdef LED_BREATHE_GAMMA_EN
        return (d * d) >> PW;
`else
        return d;
`endif
    endfunction

    // Phase of the breathe schedule k clocks after the enabling edge (k=0 is that edge).
    function automatic void rampAt(input int k, output int st, output int duty);
        int t;
        t = (k / TDIV) % PER_T;
        if (t < UT) begin
            st = 1; duty = t;
        end else if (t < UT + HT) begin
            st = 2; duty = MAXV;
        end else if (t < 2 * UT + HT) begin
            st = 3; duty = 2 * UT + HT - 1 - t;
        end else begin
            st = 4; duty = 0;
        end
    endfunction

    function automatic logic [9:0] modelObs(input int k);
        int st, d, stP, dP, chNow, chPrev;
        logic [3:0] led;
        logic done;
        rampAt(k, st, d);
        chNow = (baseCh + k / PER_CLK) % NCH;
        done  = (k > 0) && (k % PER_CLK == 0);
        led   = '0;
        if (k > 0) begin
            rampAt(k - 1, stP, dP);
            chPrev = (baseCh + (k - 1) / PER_CLK) % NCH;
            if (((k - 1) % UT) < effOf(dP)) led[chPrev] = 1'b1;
        end
        return {3'(st), 2'(chNow), done, led};
    endfunction

    task automatic startRun();
        en   = 1'b1;
        kNow = -1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        kNow++;
        expObs = modelObs(kNow);
    endtask

    task automatic stopRun();
        int chRet;
        chRet = (baseCh + kNow / PER_CLK) % NCH;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        baseCh = chRet;
    endtask

    task automatic test_reset();
        int n;
        baseCh = 0;
        startRun();
        rst = 1'b0;
        n = $urandom_range(20, 100);
        for (int i = 0; i <= n; i++) begin
            advance();
            nCheck++;
            if (obs !== expObs) begin
                nBad++;
                $display("[TB] FAIL reset_prerun k=%0d got=%h want=%h", kNow, obs, expObs);
            end
        end
        #3;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        nCheck++;
        if (obs !== 10'd0) begin
            nBad++;
            $display("[TB] FAIL reset_async got=%h want=%h", obs, 10'd0);
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            nCheck++;
            if (obs !== 10'd0) begin
                nBad++;
                $display("[TB] FAIL reset_idle clk=%0d got=%h want=%h", i, obs, 10'd0);
            end
        end
        baseCh = 0;
    endtask

    task automatic test_pwm_duty();
        int litSeen, litWant, dP;
        int st;
        startRun();
        litSeen = 0;
        litWant = 0;
        for (int i = 0; i <= UT * TDIV; i++) begin
            advance();
            nCheck++;
            if (obs !== expObs) begin
                nBad++;
                $display("[TB] FAIL pwm_step k=%0d got=%h want=%h", kNow, obs, expObs);
            end
            nCheck++;
            if (led_out[3:1] !== 3'b000) begin
                nBad++;
                $display("[TB] FAIL pwm_other k=%0d got=%b want=000", kNow, led_out[3:1]);
            end
            if (led_out[0] === 1'b1) litSeen++;
            if (kNow > 0) begin
                rampAt(kNow - 1, st, dP);
                if (((kNow - 1) % UT) < effOf(dP)) litWant++;
            end
        end
        nCheck++;
        if (litSeen !== litWant) begin
            nBad++;
            $display("[TB] FAIL pwm_litcount got=%0d want=%0d", litSeen, litWant);
        end
        stopRun();
    endtask

    task automatic test_full_cycle();
        int n, pulses, lastK;
        int pulseK[4];
        int pulseCh[4];
        startRun();
        pulses = 0;
        n = 4 * PER_CLK + $urandom_range(1, 30);
        for (int i = 0; i <= n; i++) begin
            advance();
            nCheck++;
            if (obs !== expObs) begin
                nBad++;
                $display("[TB] FAIL cycle_step k=%0d got=%h want=%h", kNow, obs, expObs);
            end
            if (cycle_done === 1'b1) begin
                if (pulses < 4) begin
                    pulseK[pulses]  = kNow;
                    pulseCh[pulses] = int'(active_ch);
                end
                pulses++;
            end
        end
        nCheck++;
        if (pulses !== 4) begin
            nBad++;
            $display("[TB] FAIL cycle_pulses got=%0d want=4", pulses);
        end
        lastK = 0;
        for (int i = 0; i < 4 && i < pulses; i++) begin
            nCheck++;
            if (pulseK[i] - lastK !== PER_CLK) begin
                nBad++;
                $display("[TB] FAIL cycle_spacing idx=%0d got=%0d want=%0d", i, pulseK[i] - lastK, PER_CLK);
            end
            nCheck++;
            if (pulseCh[i] !== (i + 1) % NCH) begin
                nBad++;
                $display("[TB] FAIL cycle_chase idx=%0d got=%0d want=%0d", i, pulseCh[i], (i + 1) % NCH);
            end
            lastK = pulseK[i];
        end
        stopRun();
    endtask

    task automatic test_disable();
        int m, chRet, idle;
        logic [9:0] want;
        for (int r = 0; r < 3; r++) begin
            startRun();
            m = $urandom_range(0, 1) * PER_CLK + $urandom_range((UT + HT) * TDIV, (2 * UT + HT) * TDIV - 1);
            for (int i = 0; i <= m; i++) begin
                advance();
                nCheck++;
                if (obs !== expObs) begin
                    nBad++;
                    $display("[TB] FAIL disable_run r=%0d k=%0d got=%h want=%h", r, kNow, obs, expObs);
                end
            end
            chRet = (baseCh + kNow / PER_CLK) % NCH;
            want  = {3'd0, 2'(chRet), 1'b0, 4'd0};
            en = 1'b0;
            idle = $urandom_range(1, 10);
            for (int i = 0; i < idle; i++) begin
                @(posedge clk);
                #1;
                nCheck++;
                if (obs !== want) begin
                    nBad++;
                    $display("[TB] FAIL disable_idle r=%0d clk=%0d got=%h want=%h", r, i, obs, want);
                end
            end
            baseCh = chRet;
        end
    endtask

    task automatic test_simultaneous();
        int c, chRet;
        logic [9:0] want;
        for (int r = 0; r < 2; r++) begin
            startRun();
            c = $urandom_range(1, 2);
            for (int i = 0; i < c * PER_CLK; i++) begin
                advance();
                nCheck++;
                if (obs !== expObs) begin
                    nBad++;
                    $display("[TB] FAIL simul_run r=%0d k=%0d got=%h want=%h", r, kNow, obs, expObs);
                end
            end
            chRet = (baseCh + c - 1) % NCH;
            want  = {3'd0, 2'(chRet), 1'b0, 4'd0};
            en = 1'b0;
            @(posedge clk);
            #1;
            nCheck++;
            if (obs !== want) begin
                nBad++;
                $display("[TB] FAIL simul_lasttick r=%0d got=%h want=%h", r, obs, want);
            end
            @(posedge clk);
            #1;
            baseCh = chRet;
        end
    endtask

    initial begin
        nCheck = 0;
        nBad   = 0;
        kNow   = -1;
        baseCh = 0;
        rst    = 1'b1;
        en     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] starting");
        test_reset();
        test_pwm_duty();
        test_full_cycle();
        test_disable();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", nCheck, nBad);
        $finish;
    end

endmodule
